// File: rtl/det_sched_pkg.sv
// det_sched_pkg: shared FSM states, width default and round-robin pick for det_job_scheduler
// Contents: DET_W_DEF, sched_state_t, rr_pick(req, ptr, n).
// S_FAULT exists only when DET_TIMEOUT_EN is defined.
package det_sched_pkg;
  localparam int DET_W_DEF = 32;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_ACK,
    S_RESP
`ifdef DET_TIMEOUT_EN
    , S_FAULT
`endif
  } sched_state_t;
  // Scans n slots starting at ptr and wrapping; the nearest set req wins.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    int j;
    rr_pick = ptr;
    for (int i = 7; i >= 0; i--) begin
      j = (int'(ptr) + i) % n;
      if (i < n && req[3'(j)]) rr_pick = 3'(j);
    end
  endfunction
endpackage

// File: rtl/det_job_scheduler_if.sv
// det_job_scheduler_if: requester and determinant-core signals of det_job_scheduler
// Requester side: req, rsp_valid, rsp_id, rsp_det, rsp_err, busy.
// Core side: mat_sel, core_start, core_ack, core_idle, core_done, core_det.
// master = scheduler, slave = requesters plus core.
interface det_job_scheduler_if
  import det_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DET_W = DET_W_DEF
);
  localparam int IDX_W = $clog2(N_REQ);
  logic [N_REQ-1:0] req;
  logic rsp_valid;
  logic [IDX_W-1:0] rsp_id;
  logic [DET_W-1:0] rsp_det;
  logic rsp_err;
  logic busy;
  logic [IDX_W-1:0] mat_sel;
  logic core_start;
  logic core_ack;
  logic core_idle;
  logic core_done;
  logic [DET_W-1:0] core_det;
  modport master (
    input req, core_idle, core_done, core_det,
    output rsp_valid, rsp_id, rsp_det, rsp_err, busy, mat_sel, core_start, core_ack
  );
  modport slave (
    output req, core_idle, core_done, core_det,
    input rsp_valid, rsp_id, rsp_det, rsp_err, busy, mat_sel, core_start, core_ack
  );
endinterface

// File: rtl/det_rr_arbiter.sv
// det_rr_arbiter: combinational round-robin pick of the first set req at or after ptr
// Ports: req (in), ptr (in), gnt_valid (out, any req set), gnt_idx (out).
module det_rr_arbiter
  import det_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);
  assign gnt_valid = |req;
  assign gnt_idx = IDX_W'(rr_pick(8'(req), 3'(ptr), N_REQ));
endmodule

// File: rtl/det_job_scheduler.sv
// det_job_scheduler: round-robin sharing of one determinant core among N_REQ requesters
// Ports: Clk, Reset (async, active-high), bus (det_job_scheduler_if.master):
//   req in, rsp_valid/rsp_id/rsp_det/rsp_err/busy out, mat_sel/core_start/core_ack out,
//   core_idle/core_done/core_det in.
// Optional: DET_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYCLES that ends in a sticky FAULT.
module det_job_scheduler
  import det_sched_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int DET_W          = DET_W_DEF,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic Clk,
  input logic Reset,
  det_job_scheduler_if.master bus
);
  localparam int IDX_W = $clog2(N_REQ);
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("det_job_scheduler: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end
  sched_state_t state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, gnt_q, id_q, arb_idx;
  logic [DET_W-1:0] det_q;
  logic arb_valid, grant, tmo;
  det_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req(bus.req),
    .ptr(rr_ptr),
    .gnt_valid(arb_valid),
    .gnt_idx(arb_idx)
  );
`ifdef DET_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) wait_cnt <= '0;
    else wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
  // A done arriving on the last allowed cycle still wins over the watchdog.
  assign tmo = state == S_WAIT && !bus.core_done && wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  assign grant = state == S_IDLE && arb_valid && bus.core_idle;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= S_IDLE;
      rr_ptr <= '0;
      gnt_q <= '0;
      id_q <= '0;
      det_q <= '0;
    end else begin
      state <= state_nxt;
      if (grant) gnt_q <= arb_idx;
      if (state == S_WAIT) det_q <= bus.core_done ? bus.core_det : tmo ? '0 : det_q;
      if (bus.rsp_valid) id_q <= gnt_q;
      if (state == S_RESP) rr_ptr <= IDX_W'((int'(gnt_q) + 1) % N_REQ);
    end
  // rsp_id/rsp_det show the live job during a pulse and hold the last result otherwise.
  always_comb begin
    state_nxt = state;
    bus.rsp_valid = state == S_RESP || tmo;
    bus.rsp_err = tmo;
    bus.rsp_id = bus.rsp_valid ? gnt_q : id_q;
    bus.rsp_det = tmo ? '0 : det_q;
    bus.busy = state != S_IDLE;
    bus.mat_sel = gnt_q;
    bus.core_start = state == S_START;
    bus.core_ack = state == S_ACK;
    case (state)
      S_IDLE:  state_nxt = grant ? S_START : S_IDLE;
      S_START: state_nxt = bus.core_idle ? S_START : S_WAIT;
`ifdef DET_TIMEOUT_EN
      S_WAIT:  state_nxt = bus.core_done ? S_ACK : tmo ? S_FAULT : S_WAIT;
`else
      S_WAIT:  state_nxt = bus.core_done ? S_ACK : S_WAIT;
`endif
      S_ACK:   state_nxt = bus.core_done ? S_ACK : S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = state;
    endcase
  end
endmodule

// File: tb/tb_det_job_scheduler.sv
// tb_det_job_scheduler: directed scoreboard bench for det_job_scheduler with a behavioural core
module tb_det_job_scheduler;
  import det_sched_pkg::*;
  localparam int N = 4;
  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] det;
    logic        err;
  } rsp_t;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;
  det_job_scheduler_if #(.N_REQ(N), .DET_W(32)) bus ();
  det_job_scheduler #(.N_REQ(N), .DET_W(32), .TIMEOUT_CYCLES(16)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );
  rsp_t sb[$];
  logic [31:0] det_tab[4] = '{32'h11, 32'h22, 32'd42, 32'hFFFF_FFF6};
  int comp_cycles = 3;
  bit hang = 1'b0;
  int passes = 0, checks = 0, fails = 0, rsp_count = 0, start_count = 0;
  logic [1:0] cst;
  int ccnt;
  logic prev_start = 1'b0;
  always @(posedge Clk or posedge Reset)
    if (Reset) begin
      cst <= 2'd0;
      ccnt <= 0;
      bus.core_idle <= 1'b1;
      bus.core_done <= 1'b0;
      bus.core_det <= '0;
    end else
      case (cst)
        2'd0: if (bus.core_start) begin
          cst <= 2'd1;
          ccnt <= 0;
          bus.core_idle <= 1'b0;
        end
        2'd1: if (!hang && ccnt >= comp_cycles) begin
          cst <= 2'd2;
          bus.core_done <= 1'b1;
          bus.core_det <= det_tab[bus.mat_sel];
        end else ccnt <= ccnt + 1;
        default: if (bus.core_ack) begin
          cst <= 2'd0;
          bus.core_done <= 1'b0;
          bus.core_idle <= 1'b1;
        end
      endcase
  always @(negedge Clk) begin
    if (bus.rsp_valid) rsp_count++;
    if (bus.core_start && !prev_start) start_count++;
    prev_start = bus.core_start;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [1:0] id, input logic [31:0] det, input logic err);
    rsp_t e;
    e.id = id;
    e.det = det;
    e.err = err;
    sb.push_back(e);
  endtask
  task automatic cmp_rsp(input string tag);
    rsp_t e;
    chk({tag, " rsp_valid"}, 64'(bus.rsp_valid), 1);
    chk({tag, " sb_nonempty"}, 64'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, " rsp_id"}, 64'(bus.rsp_id), 64'(e.id));
      chk({tag, " rsp_det"}, 64'(bus.rsp_det), 64'(e.det));
      chk({tag, " rsp_err"}, 64'(bus.rsp_err), 64'(e.err));
    end
  endtask
  task automatic get_rsp(input string tag, input int sel, output int idle_cyc);
    int n = 0;
    idle_cyc = 0;
    @(negedge Clk);
    while (!bus.rsp_valid && n < 200) begin
      if (!bus.busy) idle_cyc++;
      if (sel >= 0 && bus.busy) chk({tag, " mat_sel"}, 64'(bus.mat_sel), 64'(sel));
      n++;
      @(negedge Clk);
    end
    cmp_rsp(tag);
  endtask
  task automatic wait_wait(input string tag);
    int n = 0;
    while (!(bus.busy && !bus.core_start && !bus.core_ack && !bus.core_done && !bus.rsp_valid) && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk({tag, " reached_wait"}, 64'(n < 100), 1);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " rsp_valid"}, 64'(bus.rsp_valid), 0);
    chk({tag, " rsp_id"}, 64'(bus.rsp_id), 0);
    chk({tag, " rsp_det"}, 64'(bus.rsp_det), 0);
    chk({tag, " rsp_err"}, 64'(bus.rsp_err), 0);
    chk({tag, " busy"}, 64'(bus.busy), 0);
    chk({tag, " mat_sel"}, 64'(bus.mat_sel), 0);
    chk({tag, " core_start"}, 64'(bus.core_start), 0);
    chk({tag, " core_ack"}, 64'(bus.core_ack), 0);
  endtask
  initial begin
    int idle, s0, c0;
    bus.req = '0;
    repeat (3) @(negedge Clk);
    chk_zero("reset");
    Reset = 1'b0;
    @(negedge Clk);
    s0 = start_count;
    bus.req = 4'b0100;
    push(2'd2, 32'd42, 1'b0);
    get_rsp("single", 2, idle);
    bus.req = '0;
    @(negedge Clk);
    chk("single start_phases", 64'(start_count - s0), 1);
    chk("single pulse_width", 64'(bus.rsp_valid), 0);
    chk("single hold_id", 64'(bus.rsp_id), 2);
    chk("single hold_det", 64'(bus.rsp_det), 42);
    bus.req = 4'b1000;
    hang = 1'b1;
    wait_wait("rstwait");
    c0 = rsp_count;
    Reset = 1'b1;
    #1;
    chk_zero("rst_in_wait");
    @(negedge Clk);
    Reset = 1'b0;
    hang = 1'b0;
    bus.req = 4'b1010;
    push(2'd1, 32'h22, 1'b0);
    get_rsp("post_reset", -1, idle);
    bus.req = '0;
    @(negedge Clk);
    chk("post_reset rsp_count", 64'(rsp_count - c0), 1);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    bus.req = 4'b1111;
    push(2'd0, 32'h11, 1'b0);
    push(2'd1, 32'h22, 1'b0);
    push(2'd2, 32'd42, 1'b0);
    push(2'd3, 32'hFFFF_FFF6, 1'b0);
    push(2'd0, 32'h11, 1'b0);
    for (int k = 0; k < 5; k++) begin
      get_rsp("all_req", -1, idle);
      if (k > 0) chk("all_req idle_gap", 64'(idle), 1);
    end
    bus.req = '0;
    bus.req = 4'b1010;
    push(2'd1, 32'h22, 1'b0);
    push(2'd3, 32'hFFFF_FFF6, 1'b0);
    wait_wait("withdraw");
    bus.req = 4'b1000;
    get_rsp("withdraw", -1, idle);
    get_rsp("negative_next_rr", -1, idle);
    bus.req = '0;
    repeat (3) @(negedge Clk);
    chk("idle busy", 64'(bus.busy), 0);
    chk("sb drained", 64'(sb.size()), 0);
`ifdef DET_TIMEOUT_EN
    begin
      int n = 1;
      bus.req = 4'b0001;
      hang = 1'b1;
      push(2'd0, 32'd0, 1'b1);
      wait_wait("tmo");
      while (!bus.rsp_valid && n < 40) begin
        @(negedge Clk);
        n++;
      end
      chk("tmo wait_cycles", 64'(n), 16);
      cmp_rsp("tmo");
      bus.req = 4'b1111;
      @(negedge Clk);
      s0 = start_count;
      c0 = rsp_count;
      repeat (20) @(negedge Clk);
      chk("fault busy", 64'(bus.busy), 1);
      chk("fault no_start", 64'(start_count - s0), 0);
      chk("fault no_rsp", 64'(rsp_count - c0), 0);
      chk("fault core_ack", 64'(bus.core_ack), 0);
      bus.req = '0;
      hang = 1'b0;
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      chk("fault cleared busy", 64'(bus.busy), 0);
    end
`endif
    repeat (2) @(negedge Clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
